// File: rtl/wb_lsu_master.sv
// wb_lsu_master: Wishbone pipelined initiator for single load/store requests.
// Issues one bus cycle per request, derives byte selects from the access size,
// holds the strobe through stall, times out a silent slave, and returns
// extended load data with error status as a one-cycle response pulse.
module wb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic [31:0] wb_dat_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_n;

    // Latched request fields
    logic        we_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [1:0]  size_q;
    logic        uns_q;

    // Field view for the next cycle: live request in IDLE, latched copy otherwise
    logic        we_f;
    logic [31:0] adr_f;
    logic [31:0] dat_f;
    logic [1:0]  size_f;

    logic             hs;
    logic             timed_out;
    logic [CNT_W-1:0] count;

    // Response qualifiers produced alongside the transition into RESP
    logic rsp_err_n;
    logic rsp_to_n;
    logic load_n;

    // Next values of the registered outputs
    logic        busy_n;
    logic        ready_d;
    logic        rsp_valid_d;
    logic [31:0] rsp_rdata_d;
    logic        rsp_err_d;
    logic        rsp_to_d;
    logic        cyc_d;
    logic        stb_d;
    logic        we_d;
    logic [31:0] adr_d;
    logic [31:0] dat_d;
    logic [3:0]  sel_d;

    function automatic logic [3:0] sel_for(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] d,
                                           input logic [1:0]  size,
                                           input logic        uns);
        case (size)
            2'b00:   return uns ? {24'h000000, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   return uns ? {16'h0000, d[15:0]}   : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Handshake uses the registered ready, so nothing is accepted until the first clock after reset
    always_comb begin
        hs        = req_valid_i & req_ready_o;
        timed_out = (TIMEOUT_CYCLES != 0) && (count == CNT_LIMIT);
        we_f      = (state == IDLE) ? req_we_i    : we_q;
        adr_f     = (state == IDLE) ? req_addr_i  : adr_q;
        dat_f     = (state == IDLE) ? req_wdata_i : dat_q;
        size_f    = (state == IDLE) ? req_size_i  : size_q;
    end

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; ack/err beat a timeout landing in the same cycle, err beats ack
    always_comb begin
        state_n   = state;
        rsp_err_n = 1'b0;
        rsp_to_n  = 1'b0;
        load_n    = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    if (req_size_i == 2'b11) begin
                        state_n   = RESP;
                        rsp_err_n = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
            end
            REQ: begin
                if (!wb_stall_i && (wb_ack_i || wb_err_i)) begin
                    state_n   = RESP;
                    rsp_err_n = wb_err_i;
                    load_n    = !wb_err_i && !we_q;
                end else if (timed_out) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                    rsp_to_n  = 1'b1;
                end else if (!wb_stall_i) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (wb_err_i) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                end else if (wb_ack_i) begin
                    state_n = RESP;
                    load_n  = !we_q;
                end else if (timed_out) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                    rsp_to_n  = 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output logic: next values of every output, derived from the next state
    always_comb begin
        busy_n      = (state_n == REQ) || (state_n == WAIT);
        ready_d     = (state_n == IDLE);
        rsp_valid_d = (state_n == RESP);
        rsp_err_d   = rsp_err_n;
        rsp_to_d    = rsp_to_n;
        rsp_rdata_d = load_n ? extend(wb_dat_i, size_q, uns_q) : '0;
        cyc_d       = busy_n;
        stb_d       = (state_n == REQ);
        we_d        = busy_n & we_f;
        adr_d       = busy_n ? adr_f : '0;
        dat_d       = busy_n ? dat_f : '0;
        sel_d       = busy_n ? sel_for(size_f) : '0;
    end

    // Registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            req_ready_o   <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_sel_o      <= '0;
        end else begin
            req_ready_o   <= ready_d;
            rsp_valid_o   <= rsp_valid_d;
            rsp_rdata_o   <= rsp_rdata_d;
            rsp_err_o     <= rsp_err_d;
            rsp_timeout_o <= rsp_to_d;
            wb_cyc_o      <= cyc_d;
            wb_stb_o      <= stb_d;
            wb_we_o       <= we_d;
            wb_adr_o      <= adr_d;
            wb_dat_o      <= dat_d;
            wb_sel_o      <= sel_d;
        end
    end

    // Request latch, loaded on the handshake
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            we_q   <= 1'b0;
            adr_q  <= '0;
            dat_q  <= '0;
            size_q <= '0;
            uns_q  <= 1'b0;
        end else if (state == IDLE && hs) begin
            we_q   <= req_we_i;
            adr_q  <= req_addr_i;
            dat_q  <= req_wdata_i;
            size_q <= req_size_i;
            uns_q  <= req_unsigned_i;
        end
    end

    // Timeout counter: held at zero in IDLE, saturating count through REQ/WAIT
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            count <= '0;
        end else if (state == IDLE) begin
            count <= '0;
        end else if ((state == REQ || state == WAIT) && count != '1) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Testbench for wb_lsu_master: directed steps against a byte-addressed slave
// model, with expected responses queued at issue time and checked on rsp_valid.
module tb_wb_lsu_master;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_uns = 1'b0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stall_i = 1'b0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic [31:0] wb_dat_i = '0;

    wb_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
        .wb_clk_i       (clk),
        .wb_rst_n_i     (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .rsp_timeout_o  (rsp_timeout_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_adr_o       (wb_adr_o),
        .wb_dat_o       (wb_dat_o),
        .wb_sel_o       (wb_sel_o),
        .wb_stall_i     (wb_stall_i),
        .wb_ack_i       (wb_ack_i),
        .wb_err_i       (wb_err_i),
        .wb_dat_i       (wb_dat_i)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } rsp_t;
    rsp_t sb[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] rdata, input logic err, input logic to);
        rsp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.to    = to;
        sb.push_back(e);
    endtask

    // Slave model: byte memory, programmable stall, ack one cycle after acceptance
    logic [7:0]  mem [0:1023];
    int          stall_left = 0;
    bit          silent = 0;
    bit          err_mode = 0;
    bit          stray = 0;
    bit          pending = 0;
    int          accepts = 0;
    logic        p_we = 1'b0;
    logic [31:0] p_adr = '0;

    always @(negedge clk) begin
        logic [9:0]  ix;
        logic [31:0] rd;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_stall_i = 1'b0;
        wb_dat_i   = '0;
        if (!wb_cyc_o) begin
            pending = 0;
            if (stray) wb_ack_i = 1'b1;
        end else if (wb_stb_o) begin
            if (stall_left > 0) begin
                wb_stall_i = 1'b1;
                stall_left--;
            end else begin
                accepts++;
                pending = 1;
                p_we    = wb_we_o;
                p_adr   = wb_adr_o;
                if (wb_we_o) begin
                    for (int i = 0; i < 4; i++) begin
                        ix = wb_adr_o[9:0] + 10'(i);
                        if (wb_sel_o[i]) mem[ix] = wb_dat_o[8*i +: 8];
                    end
                end
            end
        end else if (pending) begin
            pending = 0;
            if (!silent) begin
                rd = '0;
                for (int i = 0; i < 4; i++) begin
                    ix = p_adr[9:0] + 10'(i);
                    rd[8*i +: 8] = mem[ix];
                end
                wb_ack_i = 1'b1;
                wb_err_i = err_mode;
                wb_dat_i = err_mode ? 32'hDEADBEEF : (p_we ? 32'h0 : rd);
            end
        end
    end

    // Response monitor: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        rsp_t e;
        if (rst_n && rsp_valid_o) begin
            chk("rsp_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_fields", 128'({rsp_rdata_o, rsp_err_o, rsp_timeout_o}),
                    128'({e.rdata, e.err, e.to}));
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, output int hs);
        bit done;
        done = 0;
        hs   = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        req_uns   = uns;
        for (int i = 0; i < 20 && !done; i++) begin
            if (req_ready_o) begin
                hs   = cycle;
                done = 1;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        chk("handshake", 128'(done), 128'(1));
    endtask

    task automatic wait_rsp(output int rc);
        rc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                rc = cycle;
                break;
            end
        end
        chk("rsp_arrived", 128'(rc >= 0), 128'(1));
    endtask

    function automatic logic [106:0] all_outs();
        return {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
                wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int rc;
        int acc0;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'h11;
        mem[10'h101] = 8'h22;
        mem[10'h102] = 8'h33;
        mem[10'h103] = 8'h84;

        // Reset: every output low, ready one clock after release
        repeat (2) @(negedge clk);
        chk("reset_outs", 128'(all_outs()), '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 128'(req_ready_o), 128'(1));

        // Word load
        push(32'h84332211, 1'b0, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, hs);
        chk("word_bus", 128'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, req_ready_o}),
            128'({1'b1, 1'b1, 1'b0, 4'b1111, 32'h100, 1'b0}));
        wait_rsp(rc);
        chk("word_latency", 128'(rc - hs), 128'(3));
        chk("rsp_no_cyc", 128'(wb_cyc_o), 128'(0));
        @(negedge clk);
        chk("ready_again", 128'({req_ready_o, rsp_valid_o}), 128'({1'b1, 1'b0}));

        // Byte loads, signed and unsigned
        push(32'hFFFFFF84, 1'b0, 1'b0);
        issue(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, hs);
        chk("byte_sel", 128'({wb_sel_o, wb_adr_o}), 128'({4'b0001, 32'h103}));
        wait_rsp(rc);
        push(32'h00000084, 1'b0, 1'b0);
        issue(1'b0, 32'h103, 32'h0, 2'b00, 1'b1, hs);
        chk("ubyte_sel", 128'(wb_sel_o), 128'(4'b0001));
        wait_rsp(rc);

        // Half store, then read back as word and as halves
        push(32'h0, 1'b0, 1'b0);
        issue(1'b1, 32'h201, 32'h0000BEEF, 2'b01, 1'b0, hs);
        chk("half_store_bus", 128'({wb_we_o, wb_sel_o, wb_dat_o[15:0], wb_adr_o}),
            128'({1'b1, 4'b0011, 16'hBEEF, 32'h201}));
        wait_rsp(rc);
        push(32'h00BEEF00, 1'b0, 1'b0);
        issue(1'b0, 32'h200, 32'h0, 2'b10, 1'b0, hs);
        wait_rsp(rc);
        push(32'hFFFFBEEF, 1'b0, 1'b0);
        issue(1'b0, 32'h201, 32'h0, 2'b01, 1'b0, hs);
        wait_rsp(rc);
        push(32'h0000BEEF, 1'b0, 1'b0);
        issue(1'b0, 32'h201, 32'h0, 2'b01, 1'b1, hs);
        wait_rsp(rc);

        // Three stall cycles: strobe and fields stable, one acceptance
        acc0 = accepts;
        stall_left = 3;
        push(32'h84332211, 1'b0, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, hs);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_hold", 128'({wb_stb_o, wb_adr_o, wb_sel_o}),
                128'({1'b1, 32'h100, 4'b1111}));
        end
        wait_rsp(rc);
        chk("stall_latency", 128'(rc - hs), 128'(6));
        chk("stall_accepts", 128'(accepts - acc0), 128'(1));

        // ack and err together in WAIT
        err_mode = 1;
        push(32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, hs);
        wait_rsp(rc);
        chk("err_latency", 128'(rc - hs), 128'(3));
        err_mode = 0;

        // Silent slave: timeout
        silent = 1;
        push(32'h0, 1'b1, 1'b1);
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, hs);
        chk("to_cyc_high", 128'(wb_cyc_o), 128'(1));
        wait_rsp(rc);
        chk("to_latency", 128'(rc - hs), 128'(TO + 2));
        chk("to_cyc_dropped", 128'(wb_cyc_o), 128'(0));
        silent = 0;

        // Reserved size: immediate error, no bus cycle
        acc0 = accepts;
        push(32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 2'b11, 1'b0, hs);
        chk("rsv_no_cyc", 128'({wb_cyc_o, wb_stb_o}), 128'(0));
        wait_rsp(rc);
        chk("rsv_latency", 128'(rc - hs), 128'(1));
        chk("rsv_accepts", 128'(accepts - acc0), 128'(0));

        // Reset during WAIT abandons the cycle
        silent = 1;
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, hs);
        @(negedge clk);
        @(negedge clk);
        chk("in_wait", 128'({wb_cyc_o, wb_stb_o}), 128'({1'b1, 1'b0}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 128'(all_outs()), '0);
        silent = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst2", 128'(req_ready_o), 128'(1));
        push(32'h84332211, 1'b0, 1'b0);
        issue(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, hs);
        wait_rsp(rc);
        chk("post_reset_latency", 128'(rc - hs), 128'(3));

        // Stray ack while idle is ignored
        @(negedge clk);
        stray = 1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_ignored", 128'({rsp_valid_o, wb_cyc_o, req_ready_o}),
                128'({1'b0, 1'b0, 1'b1}));
        end
        stray = 0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
